// File: rtl/step_seq_pkg.sv
// Shared types and constants for the step sequencer.
// STEP_SEQ_HALF_STEP_EN selects the 8-entry half-step table instead of full-step.
package step_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned CNT_W = 8;

  localparam logic [3:0] FULL_TABLE [4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
  localparam logic [3:0] HALF_TABLE [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                           4'b0100, 4'b1100, 4'b1000, 4'b1001};

`ifdef STEP_SEQ_HALF_STEP_EN
  localparam int unsigned TBL_LEN = 8;
  localparam int unsigned IDX_W   = 3;
`else
  localparam int unsigned TBL_LEN = 4;
  localparam int unsigned IDX_W   = 2;
`endif

  function automatic logic [3:0] phase_lut(input logic [IDX_W-1:0] idx);
    if (TBL_LEN == 8) return HALF_TABLE[3'(idx)];
    else              return FULL_TABLE[2'(idx)];
  endfunction

endpackage

// File: rtl/step_sequencer_if.sv
// Command/status bundle between the control datapath and the step sequencer.
interface step_sequencer_if;

  logic                                      start;
  logic signed [step_seq_pkg::CNT_W-1:0]     steps;
  logic                                      abort;
  logic                                      busy;
  logic                                      done;
  logic                                      step_pulse;
  logic        [3:0]                         phase;
  logic signed [step_seq_pkg::CNT_W-1:0]     remaining;
  logic                                      negative;
  logic                                      positive;
  logic                                      zero;

  modport master (
    output start, steps, abort,
    input  busy, done, step_pulse, phase, remaining, negative, positive, zero
  );

  modport slave (
    input  start, steps, abort,
    output busy, done, step_pulse, phase, remaining, negative, positive, zero
  );

endinterface

// File: rtl/step_timer.sv
// Step-interval divider: counts 0..STEP_PERIOD-1 while enabled, tick on the last count.
module step_timer #(
  parameter int unsigned STEP_PERIOD = 16,
  parameter int unsigned DIV_W       = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  logic [DIV_W-1:0] r_div;

  assign o_tick = (r_div == DIV_W'(STEP_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (!reset_n || i_clear) begin
      r_div <= '0;
    end else if (i_enable) begin
      r_div <= o_tick ? '0 : r_div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// Signed step-count sequencer driving stepper coil phases at a fixed step rate.
// Build option STEP_SEQ_HALF_STEP_EN selects half-step phase sequencing.
module step_sequencer
  import step_seq_pkg::*;
#(
  parameter int unsigned STEP_PERIOD = 16,
  parameter int unsigned DIV_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  step_sequencer_if.slave  bus
);

  state_t                  r_state, w_state_nxt;
  logic signed [CNT_W-1:0] r_remaining, w_remaining_nxt, w_remaining_step;
  logic [IDX_W-1:0]        r_idx, w_idx_nxt;
  logic                    r_step_pulse, w_step_pulse_nxt;
  logic                    w_tick, w_timer_clear, w_timer_en;

  step_timer #(
    .STEP_PERIOD(STEP_PERIOD),
    .DIV_W      (DIV_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (w_timer_clear),
    .i_enable(w_timer_en),
    .o_tick  (w_tick)
  );

  // Remaining always moves toward zero, so -128 never overflows.
  assign w_remaining_step = r_remaining[CNT_W-1] ? r_remaining + CNT_W'(1)
                                                 : r_remaining - CNT_W'(1);

  always_comb begin
    w_state_nxt      = r_state;
    w_remaining_nxt  = r_remaining;
    w_idx_nxt        = r_idx;
    w_step_pulse_nxt = 1'b0;
    w_timer_clear    = 1'b1;
    w_timer_en       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_remaining_nxt = bus.steps;
          w_state_nxt     = (bus.steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        w_timer_clear = 1'b0;
        if (bus.abort) begin
          w_state_nxt = IDLE;
        end else begin
          w_timer_en = 1'b1;
          if (w_tick) begin
            w_step_pulse_nxt = 1'b1;
            w_remaining_nxt  = w_remaining_step;
            w_idx_nxt        = r_remaining[CNT_W-1] ? r_idx - IDX_W'(1) : r_idx + IDX_W'(1);
            if (w_remaining_step == '0) w_state_nxt = DONE;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_remaining  <= '0;
      r_idx        <= '0;
      r_step_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_remaining  <= w_remaining_nxt;
      r_idx        <= w_idx_nxt;
      r_step_pulse <= w_step_pulse_nxt;
    end
  end

  assign bus.busy       = (r_state == RUN);
  assign bus.done       = (r_state == DONE);
  assign bus.step_pulse = r_step_pulse;
  assign bus.phase      = phase_lut(r_idx);
  assign bus.remaining  = r_remaining;
  assign bus.negative   = r_remaining[CNT_W-1];
  assign bus.zero       = (r_remaining == '0);
  assign bus.positive   = !r_remaining[CNT_W-1] && (r_remaining != '0);

endmodule

// File: tb/tb_step_sequencer.sv
// Testbench for step_sequencer: directed move table plus randomized moves against an arithmetic model.
module tb_step_sequencer;

  localparam int P = 4;
`ifdef STEP_SEQ_HALF_STEP_EN
  localparam int L = 8;
`else
  localparam int L = 4;
`endif

  typedef struct {
    int steps;
    int abort_at;
    int start_at;
    int reset_at;
    int exp_pulses;
    int exp_final;
  } move_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;
  int   model_idx = 0;

  step_sequencer_if sif ();

  step_sequencer #(
    .STEP_PERIOD(P),
    .DIV_W      (4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (sif.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic [3:0] exp_phase(input int i);
    int m;
    m = ((i % L) + L) % L;
`ifdef STEP_SEQ_HALF_STEP_EN
    case (m)
      0: return 4'b0001;
      1: return 4'b0011;
      2: return 4'b0010;
      3: return 4'b0110;
      4: return 4'b0100;
      5: return 4'b1100;
      6: return 4'b1000;
      default: return 4'b1001;
    endcase
`else
    case (m)
      0: return 4'b0011;
      1: return 4'b0110;
      2: return 4'b1100;
      default: return 4'b1001;
    endcase
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input int rem, input int idx,
                               input bit pulse, input bit busy, input bit done);
    check({tag, ".remaining"}, int'($signed(sif.remaining)), rem);
    check({tag, ".phase"}, int'(sif.phase), int'(exp_phase(idx)));
    check({tag, ".step_pulse"}, int'(sif.step_pulse), int'(pulse));
    check({tag, ".busy"}, int'(sif.busy), int'(busy));
    check({tag, ".done"}, int'(sif.done), int'(done));
    check({tag, ".flags"}, int'({sif.negative, sif.positive, sif.zero}),
          int'({rem < 0, rem > 0, rem == 0}));
  endtask

  // Each cycle c after the accepting edge E0 is predicted from c/P, clipped to the move length.
  task automatic run_move(input move_t mv, input string tag);
    int s, n, sg, idx0, k, pulses;
    s      = mv.steps;
    n      = (s < 0) ? -s : s;
    sg     = (s < 0) ? -1 : 1;
    idx0   = model_idx;
    pulses = 0;
    sif.steps = 8'(s);
    sif.start = 1'b1;
    reset_n   = 1'b1;
    cyc();
    sif.start = 1'b0;
    for (int c = 0; c <= n * P + 1; c++) begin
      pulses += int'(sif.step_pulse);
      if (mv.reset_at != 0 && c == mv.reset_at) begin
        check_outputs({tag, ".rst"}, 0, 0, 1'b0, 1'b0, 1'b0);
        model_idx = 0;
        reset_n   = 1'b1;
        break;
      end
      if (mv.abort_at != 0 && c == mv.abort_at) begin
        k = (c - 1) / P;
        check_outputs({tag, ".abort"}, s - sg * k, idx0 + sg * k, 1'b0, 1'b0, 1'b0);
        model_idx = idx0 + sg * k;
        sif.abort = 1'b0;
        break;
      end
      k = c / P;
      if (k > n) k = n;
      check_outputs(tag, s - sg * k, idx0 + sg * k,
                    (c > 0) && (c % P == 0) && (c / P <= n),
                    (n > 0) && (c < n * P), c == n * P);
      model_idx = idx0 + sg * k;
      sif.abort = (c + 1 == mv.abort_at);
      sif.start = (c + 1 == mv.start_at);
      if (sif.start) sif.steps = 8'(-7);
      reset_n = !(c + 1 == mv.reset_at);
      cyc();
    end
    sif.start = 1'b0;
    sif.abort = 1'b0;
    check({tag, ".pulse_count"}, pulses, mv.exp_pulses);
    check({tag, ".final_remaining"}, int'($signed(sif.remaining)), mv.exp_final);
  endtask

  move_t table_v [9];
  move_t mv;

  initial begin
    sif.start = 1'b0;
    sif.abort = 1'b0;
    sif.steps = '0;
    reset_n   = 1'b0;
    repeat (3) cyc();
    check_outputs("reset", 0, 0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    // Abort asserted in IDLE must not disturb anything.
    sif.abort = 1'b1;
    cyc();
    sif.abort = 1'b0;
    check_outputs("idle_abort", 0, 0, 1'b0, 1'b0, 1'b0);

    table_v[0] = '{steps:    3, abort_at: 0, start_at: 0, reset_at: 0,  exp_pulses:   3, exp_final: 0};
    table_v[1] = '{steps:    1, abort_at: 0, start_at: 0, reset_at: 0,  exp_pulses:   1, exp_final: 0};
    table_v[2] = '{steps:   -2, abort_at: 0, start_at: 0, reset_at: 0,  exp_pulses:   2, exp_final: 0};
    table_v[3] = '{steps:    0, abort_at: 0, start_at: 0, reset_at: 0,  exp_pulses:   0, exp_final: 0};
    table_v[4] = '{steps:    5, abort_at: 0, start_at: 6, reset_at: 0,  exp_pulses:   5, exp_final: 0};
    table_v[5] = '{steps:    2, abort_at: 8, start_at: 0, reset_at: 0,  exp_pulses:   1, exp_final: 1};
    table_v[6] = '{steps:    4, abort_at: 0, start_at: 0, reset_at: 0,  exp_pulses:   4, exp_final: 0};
    table_v[7] = '{steps: -128, abort_at: 0, start_at: 0, reset_at: 0,  exp_pulses: 128, exp_final: 0};
    table_v[8] = '{steps:   50, abort_at: 0, start_at: 0, reset_at: 10, exp_pulses:   2, exp_final: 0};

    for (int i = 0; i < 9; i++) begin
      run_move(table_v[i], $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 25; i++) begin
      int s, n;
      s = int'($urandom_range(0, 40)) - 20;
      n = (s < 0) ? -s : s;
      mv = '{steps: s, abort_at: 0, start_at: 0, reset_at: 0, exp_pulses: n, exp_final: 0};
      if (n > 0 && $urandom_range(0, 3) == 0) begin
        mv.abort_at   = int'($urandom_range(1, n * P));
        mv.exp_pulses = (mv.abort_at - 1) / P;
        mv.exp_final  = s - ((s < 0) ? -1 : 1) * mv.exp_pulses;
      end
      if (n > 1 && $urandom_range(0, 2) == 0) begin
        mv.start_at = int'($urandom_range(1, n * P - 1));
      end
      run_move(mv, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
# step_sequencer

Consumes a signed step count and drives the stepper coils one step at a time at a fixed step rate. The count decays toward zero as steps are issued. The block sits between the control datapath and the motor driver pins. It exposes the remaining count with sign/zero flags and signals completion with a one-cycle done pulse.

## Interface
- STEP_PERIOD, default 16, clock cycles per step; legal range is 2 or more.
- DIV_W, default 16, width of the step-interval divider; 2**DIV_W must be at least STEP_PERIOD.

- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk
- start  in  1  begin a move; sampled only in IDLE
- steps  in  8  signed step count; sign gives direction, magnitude gives number of steps
- abort  in  1  stop a move in RUN immediately
- busy  out  1  high in RUN only
- done  out  1  one-cycle pulse in DONE
- step_pulse  out  1  one-cycle pulse on each step
- phase  out  4  coil drive pattern
- remaining  out  8  signed steps still to issue
- negative, positive, zero  out  1 each  combinational decode of remaining (<0, >0, ==0)

## Operation
- States are IDLE, RUN and DONE.
- IDLE with start=1:
  - remaining ← steps.
  - div ← 0.
  - If steps==0, go to DONE; otherwise go to RUN.
- RUN, on each edge:
  - If abort=1: go to IDLE with no step issued. phase and remaining are held, and done is never raised.
  - Else if div==STEP_PERIOD-1, issue a step:
    - div ← 0.
    - step_pulse ← 1.
    - Phase index moves +1 if remaining>0, or −1 if remaining<0, modulo the table length.
    - remaining moves one step toward zero.
    - If the new remaining is 0, go to DONE.
  - Else div ← div+1.
- DONE: go to IDLE on the next edge. start is ignored in DONE.
- start is ignored in RUN. abort has no effect in IDLE or DONE.
- steps = −128 gives 128 steps. There is no overflow because remaining only moves toward zero.
- The phase index persists across moves, so the motor holds its position. Only reset clears it.
- Full-step table, index 0 to 3: 0011, 0110, 1100, 1001.
- Reset values: state IDLE, div 0, phase index 0 (phase=0011), remaining 0 (zero=1, negative=0, positive=0), busy 0, done 0, step_pulse 0.
- Reset asserted mid-move overrides everything on that edge and discards the move.

## Timing
- Label the edge that accepts start as E0. RUN begins after E0, with busy=1 from the cycle following E0.
- Step k updates phase, remaining and step_pulse at edge E(k·STEP_PERIOD).
- step_pulse is high for exactly the one cycle after each step edge.
- After the last step edge E(n·STEP_PERIOD):
  - busy=0 and done=1 for one cycle.
  - IDLE is reached one edge later.
  - The next start can be accepted at edge E(n·STEP_PERIOD+2).
- A zero-step move has done=1 in the cycle after E0, with busy never high and no step_pulse.
- abort and a step falling on the same edge: abort wins.
- Flags are combinational from the remaining register, so they carry no lag.

## Configuration
- Macro STEP_SEQ_HALF_STEP_EN.
- Defined: 8-entry half-step table, index 0 to 7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001. The reset phase is 0001.
- Undefined: the 4-entry full-step table above, with reset phase 0011.
- Counting, timing and flags are identical in both builds.

## Structure
- Package step_seq_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - both phase tables as constant arrays;
  - table-length and index-width constants, selected by STEP_SEQ_HALF_STEP_EN;
  - the 8-bit count width constant.
- Sub-module step_timer is the DIV_W-bit interval divider. It has clear and enable inputs and a tick output that is high when div==STEP_PERIOD-1.
- The top level holds the FSM, the phase index and the remaining count.

## Test plan
- Reset check: hold reset_n=0 for 3 cycles → phase=0011, remaining=0, zero=1, busy=0, done=0.
- Forward move: STEP_PERIOD=4, start with steps=+3 →
  - step_pulse at edges E4, E8, E12;
  - phase goes 0110, 1100, 1001;
  - remaining goes 2, 1, 0;
  - done=1 in the cycle after E12.
- Reverse with wrap: steps=−2 from index 0 → phase goes 1001 then 1100, negative=1 until remaining=0, then done.
- Zero and ignore rules: steps=0 → done the cycle after E0 with no step_pulse. A start pulse during RUN leaves remaining unaffected.
- Abort coinciding with the second step edge → no step applied, remaining=1 held, IDLE reached, done never asserted. A subsequent start is accepted next cycle.
- Extreme count and mid-move reset: steps=−128 → 128 step_pulses, final remaining=0. Reset asserted mid-move → all outputs return to reset values on that edge.
